// File: rtl/dispatch_queue.sv
// In-order dispatch queue: buffers renamed op groups and drains them, oldest first, onto the
// reservation-station write ports. Optional stall counter is enabled by DISPATCH_QUEUE_PERF_EN.
`ifndef DECODE_WIDTH
`define DECODE_WIDTH 2
`endif

package dispatch_queue_pkg;

  typedef struct packed {
    logic [5:0] rob_idx;
    logic [6:0] prd;
    logic [6:0] prs1;
    logic [6:0] prs2;
    logic       prs1_rdy;
    logic       prs2_rdy;
  } RsBaseSt;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] fu_sel;
    logic       imm_en;
  } OptionCodeSt;

endpackage

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned IN_WIDTH    = `DECODE_WIDTH,
  parameter int unsigned BANK_NUM    = 2,
  parameter type         OPTION_CODE = OptionCodeSt
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush_i,
  input  logic [IN_WIDTH-1:0]       in_valid_i,
  input  RsBaseSt [IN_WIDTH-1:0]    in_base_i,
  input  OPTION_CODE [IN_WIDTH-1:0] in_oc_i,
  output logic                      in_ready_o,
  output logic [BANK_NUM-1:0]       rs_valid_o,
  output RsBaseSt [BANK_NUM-1:0]    rs_base_o,
  output OPTION_CODE [BANK_NUM-1:0] rs_oc_o,
  input  logic [BANK_NUM-1:0]       rs_ready_i
`ifdef DISPATCH_QUEUE_PERF_EN
  ,
  output logic [31:0]               perf_stall_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  RsBaseSt    r_base_mem [DEPTH];
  OPTION_CODE r_oc_mem   [DEPTH];

  logic          w_push;
  logic [CW-1:0] w_lane_cnt;
  logic [CW-1:0] w_push_cnt;
  logic [PW-1:0] w_wr_idx [IN_WIDTH];

  logic [CW-1:0] w_pop_cnt;
  logic          w_fire_chain;
  logic          w_rdy_prefix;
  logic [PW-1:0] w_rd_idx;

  // Admission looks only at the registered count, so a whole group either fits or waits.
  assign in_ready_o = (r_count <= CW'(DEPTH - IN_WIDTH));
  assign w_push     = in_ready_o & ~flush_i & (|in_valid_i);

  // Compact valid lanes: each valid lane lands at tail + (number of valid lanes below it).
  // NOTE: every always_comb output gets a default before any conditional logic, so no latch can form.
  always_comb begin
    w_lane_cnt = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_wr_idx[i] = r_tail + PW'(w_lane_cnt);
      if (in_valid_i[i]) begin
        w_lane_cnt = w_lane_cnt + CW'(1);
      end
    end
    w_push_cnt = w_push ? w_lane_cnt : '0;
  end

  // NOTE: the payload array has no reset; only pointers and count decide which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (w_push && in_valid_i[i]) begin
        r_base_mem[w_wr_idx[i]] <= in_base_i[i];
        r_oc_mem[w_wr_idx[i]]   <= in_oc_i[i];
      end
    end
  end

  // Port k offers entry head+k; it is valid only if every lower port is ready, keeping order.
  always_comb begin
    w_pop_cnt    = '0;
    w_fire_chain = 1'b1;
    w_rdy_prefix = 1'b1;
    w_rd_idx     = r_head;
    for (int k = 0; k < BANK_NUM; k++) begin
      w_rd_idx      = r_head + PW'(k);
      rs_base_o[k]  = r_base_mem[w_rd_idx];
      rs_oc_o[k]    = r_oc_mem[w_rd_idx];
      rs_valid_o[k] = (r_count > CW'(k)) && w_rdy_prefix;
      if (w_fire_chain && rs_valid_o[k] && rs_ready_i[k]) begin
        w_pop_cnt = w_pop_cnt + CW'(1);
      end else begin
        w_fire_chain = 1'b0;
      end
      w_rdy_prefix = w_rdy_prefix & rs_ready_i[k];
    end
  end

  // Flush outranks push and pop; full/empty come from the count alone.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PW'(w_pop_cnt);
      r_tail  <= r_tail + PW'(w_push_cnt);
      r_count <= r_count + w_push_cnt - w_pop_cnt;
    end
  end

`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0] r_perf_stall;

  // Counts cycles where rename offers work but the queue cannot take it; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall <= '0;
    end else if ((|in_valid_i) && !in_ready_o && !flush_i && (r_perf_stall != 32'hFFFF_FFFF)) begin
      r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_stall_o = r_perf_stall;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed self-checking bench for dispatch_queue (DEPTH=8, IN_WIDTH=2, BANK_NUM=2).
// Op identity is carried in rob_idx and mirrored in the low bits of the option code.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  flush_i;
  logic [1:0]            in_valid_i;
  RsBaseSt [1:0]         in_base_i;
  OptionCodeSt [1:0]     in_oc_i;
  logic                  in_ready_o;
  logic [1:0]            rs_valid_o;
  RsBaseSt [1:0]         rs_base_o;
  OptionCodeSt [1:0]     rs_oc_o;
  logic [1:0]            rs_ready_i;
`ifdef DISPATCH_QUEUE_PERF_EN
  logic [31:0]           perf_stall_o;
`endif

  int tests = 0;
  int fails = 0;

  int          exp_q[$];
  int          pushed;
  int          got;
  int          cyc;
  int          mcnt;
  int          n_pop;
  logic        acc;
  logic        v0;
  logic        v1;
  logic [1:0]  pat [3] = '{2'b01, 2'b11, 2'b00};

  dispatch_queue #(
    .DEPTH    (8),
    .IN_WIDTH (2),
    .BANK_NUM (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_base_i  (in_base_i),
    .in_oc_i    (in_oc_i),
    .in_ready_o (in_ready_o),
    .rs_valid_o (rs_valid_o),
    .rs_base_o  (rs_base_o),
    .rs_oc_o    (rs_oc_o),
    .rs_ready_i (rs_ready_i)
`ifdef DISPATCH_QUEUE_PERF_EN
    ,
    .perf_stall_o (perf_stall_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic RsBaseSt mk_base(input int id);
    RsBaseSt b;
    b          = '0;
    b.rob_idx  = 6'(id);
    b.prd      = 7'(id + 1);
    b.prs1     = 7'(id + 2);
    b.prs2     = 7'(id + 3);
    b.prs1_rdy = 1'b1;
    return b;
  endfunction

  function automatic OptionCodeSt mk_oc(input int id);
    OptionCodeSt o;
    o        = '0;
    o.opcode = 4'(id);
    o.fu_sel = 3'(id);
    return o;
  endfunction

  task automatic set_in(input logic [1:0] v, input int id0, input int id1);
    in_valid_i   = v;
    in_base_i[0] = mk_base(id0);
    in_base_i[1] = mk_base(id1);
    in_oc_i[0]   = mk_oc(id0);
    in_oc_i[1]   = mk_oc(id1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_port(input string tag, input int k, input int id);
    logic [31:0] obs;
    logic [31:0] exp;
    obs = {22'd0, rs_base_o[k].rob_idx, rs_oc_o[k].opcode};
    exp = {22'd0, 6'(id), 4'(id)};
    check(tag, obs, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    flush_i    = 1'b0;
    rs_ready_i = 2'b00;
    set_in(2'b00, 0, 0);
    #12;
    check("reset_rs_valid", 32'(rs_valid_o), 32'h0);
    check("reset_in_ready", 32'(in_ready_o), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    // Two ops in, both ports drain them the next cycle.
    rs_ready_i = 2'b11;
    set_in(2'b11, 1, 2);
    #1;
    check("ab_no_bypass", 32'(rs_valid_o), 32'h0);
    tick();
    set_in(2'b00, 0, 0);
    #1;
    check("ab_valid", 32'(rs_valid_o), 32'h3);
    check_port("ab_port0", 0, 1);
    check_port("ab_port1", 1, 2);
    tick();
    check("ab_empty", 32'(rs_valid_o), 32'h0);

    // Only lane 1 valid: op C compacts onto the tail slot.
    set_in(2'b10, 63, 3);
    tick();
    set_in(2'b00, 0, 0);
    #1;
    check("c_valid", 32'(rs_valid_o), 32'h1);
    check_port("c_port0", 0, 3);
    tick();
    check("c_empty", 32'(rs_valid_o), 32'h0);

    // Fill to 7 with ports stalled; credit returns only the cycle after a pop.
    rs_ready_i = 2'b00;
    set_in(2'b11, 10, 11); tick();
    set_in(2'b11, 12, 13); tick();
    set_in(2'b11, 14, 15); tick();
    set_in(2'b00, 0, 0);
    #1;
    check("cnt6_ready", 32'(in_ready_o), 32'h1);
    set_in(2'b01, 16, 0); tick();
    set_in(2'b00, 0, 0);
    #1;
    check("cnt7_not_ready", 32'(in_ready_o), 32'h0);
    check("cnt7_valid_stalled", 32'(rs_valid_o), 32'h1);
    check_port("cnt7_head", 0, 10);
    set_in(2'b11, 40, 41);
    tick();
    set_in(2'b00, 0, 0);
    rs_ready_i = 2'b01;
    #1;
    check("pop1_valid", 32'(rs_valid_o), 32'h3);
    check("pop1_no_credit", 32'(in_ready_o), 32'h0);
    check_port("pop1_port0", 0, 10);
    tick();
    rs_ready_i = 2'b11;
    #1;
    check("pop1_credit", 32'(in_ready_o), 32'h1);
    check_port("drain_a0", 0, 11);
    check_port("drain_a1", 1, 12);
    tick();
    check_port("drain_b0", 0, 13);
    check_port("drain_b1", 1, 14);
    tick();
    check_port("drain_c0", 0, 15);
    check_port("drain_c1", 1, 16);
    tick();
    check("drain_empty", 32'(rs_valid_o), 32'h0);

    // Continuous stream of 12 ops against a small reference queue; pointers wrap.
    exp_q.delete();
    pushed = 0;
    got    = 0;
    cyc    = 0;
    while (got < 12 && cyc < 60) begin
      rs_ready_i = pat[cyc % 3];
      mcnt       = exp_q.size();
      acc        = (pushed < 12) && (mcnt <= 6);
      if (acc) set_in(2'b11, 20 + pushed, 21 + pushed);
      else     set_in(2'b00, 0, 0);
      #1;
      check("stream_in_ready", 32'(in_ready_o), 32'(mcnt <= 6));
      v0 = (mcnt > 0);
      v1 = (mcnt > 1) && rs_ready_i[0];
      check("stream_valid", 32'(rs_valid_o), {30'd0, v1, v0});
      n_pop = 0;
      if (v0 && rs_ready_i[0]) begin
        check_port("stream_port0", 0, exp_q[0]);
        n_pop = 1;
        if (v1 && rs_ready_i[1]) begin
          check_port("stream_port1", 1, exp_q[1]);
          n_pop = 2;
        end
      end
      tick();
      for (int i = 0; i < n_pop; i++) void'(exp_q.pop_front());
      got += n_pop;
      if (acc) begin
        exp_q.push_back(20 + pushed);
        exp_q.push_back(21 + pushed);
        pushed += 2;
      end
      cyc++;
    end
    set_in(2'b00, 0, 0);
    check("stream_all_out", 32'(got), 32'd12);
    rs_ready_i = 2'b11;
    #1;
    check("stream_empty", 32'(rs_valid_o), 32'h0);

    // Flush with five queued and a push in the same cycle.
    rs_ready_i = 2'b00;
    set_in(2'b11, 40, 41); tick();
    set_in(2'b11, 42, 43); tick();
    set_in(2'b01, 44, 0);  tick();
    flush_i = 1'b1;
    set_in(2'b11, 45, 46);
    tick();
    flush_i = 1'b0;
    set_in(2'b00, 0, 0);
    rs_ready_i = 2'b11;
    #1;
    check("flush_valid", 32'(rs_valid_o), 32'h0);
    check("flush_ready", 32'(in_ready_o), 32'h1);
    set_in(2'b01, 50, 0);
    #1;
    check("post_flush_no_bypass", 32'(rs_valid_o), 32'h0);
    tick();
    set_in(2'b00, 0, 0);
    #1;
    check("post_flush_valid", 32'(rs_valid_o), 32'h1);
    check_port("post_flush_port0", 0, 50);
    tick();
    check("post_flush_empty", 32'(rs_valid_o), 32'h0);

    // Asynchronous reset in the middle of a cycle drops queued ops at once.
    rs_ready_i = 2'b00;
    set_in(2'b11, 60, 61);
    tick();
    set_in(2'b00, 0, 0);
    #1;
    check("pre_reset_valid", 32'(rs_valid_o), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(rs_valid_o), 32'h0);
    check("async_reset_ready", 32'(in_ready_o), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
`ifdef DISPATCH_QUEUE_PERF_EN
    check("perf_after_reset", perf_stall_o, 32'd0);
`endif

    // Completely full queue with rename still offering a group for three cycles.
    set_in(2'b11, 30, 31); tick();
    set_in(2'b11, 32, 33); tick();
    set_in(2'b11, 34, 35); tick();
    set_in(2'b11, 36, 37); tick();
    set_in(2'b11, 38, 39);
    #1;
    check("full_not_ready", 32'(in_ready_o), 32'h0);
    tick();
    tick();
    tick();
    set_in(2'b00, 0, 0);
    #1;
    check("full_head", 32'(rs_valid_o), 32'h1);
    check_port("full_head_port0", 0, 30);
`ifdef DISPATCH_QUEUE_PERF_EN
    check("perf_stall_3", perf_stall_o, 32'd3);
`endif
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("final_empty", 32'(rs_valid_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
